// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit serializer.
// Line encodings are {dplus, dminus}; the CRC16 constants are used only when USB_TX_CRC16_EN is defined.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_CRC,
        ST_ABORT,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_e;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    // x^16+x^15+x^2+1 in reflected form, shifted out LSB first
    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

    localparam int STUFF_THRESH = 6;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_tx_line_encoder.sv
// Bit stuffer, NRZI encoder and registered J/K/SE0 line driver.
// stall tells the serializer that the next load slot is consumed by a stuff bit.
module usb_tx_line_encoder
    import usb_tx_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic load,
    input  logic bit_in,
    input  logic force_se0,
    input  logic force_j,
    input  logic stuff_disable,
    output logic stall,
    output logic dplus_out,
    output logic dminus_out
);

    logic [1:0] line_q, line_d;
    logic [2:0] ones_q, ones_d;
    logic [2:0] ones_base;
    logic       ref_j;
    logic [1:0] hold_line;
    logic [1:0] toggle_line;

    always_comb begin
        ones_base   = clear ? 3'd0 : ones_q;
        // a new packet always starts its NRZI reference at J
        ref_j       = clear || (line_q == LINE_J);
        hold_line   = ref_j ? LINE_J : LINE_K;
        toggle_line = ref_j ? LINE_K : LINE_J;
        stall       = (ones_base == 3'(STUFF_THRESH));

        line_d = line_q;
        ones_d = ones_base;
        if (load) begin
            if (stall) begin
                line_d = toggle_line;
                ones_d = 3'd0;
            end else if (force_se0) begin
                line_d = LINE_SE0;
                ones_d = 3'd0;
            end else if (force_j) begin
                line_d = LINE_J;
                ones_d = 3'd0;
            end else if (!bit_in) begin
                line_d = toggle_line;
                ones_d = 3'd0;
            end else if (stuff_disable) begin
                // abort ones are never counted, so no stuff bit can follow them
                line_d = hold_line;
                ones_d = 3'd0;
            end else begin
                line_d = hold_line;
                ones_d = ones_base + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            line_q <= LINE_J;
            ones_q <= 3'd0;
        end else begin
            line_q <= line_d;
            ones_q <= ones_d;
        end
    end

    assign dplus_out  = line_q[1];
    assign dminus_out = line_q[0];

endmodule

// File: rtl/usb_tx_serializer.sv
// USB full-speed transmit serializer: SYNC, byte fetch, LSB-first shift, underrun abort and EOP.
// Optional CRC16 append is built only when USB_TX_CRC16_EN is defined.
module usb_tx_serializer
    import usb_tx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 8,
    parameter logic [7:0] SYNC_BYTE    = 8'h80,
    parameter int         EOP_SE0_BITS = 2
) (
    input  logic      clk,
    input  logic      n_rst,
    input  logic      tx_start,
    input  logic      crc_append,
    input  logic [7:0] byte_data,
    input  logic      byte_valid,
    input  logic      byte_last,
    output logic      byte_ready,
    output logic      tx_active,
    output logic      tx_error,
    output logic      dplus_out,
    output logic      dminus_out,
    output tx_state_e dbg_state
);

    // Handshake: a byte transfers on the clock edge ending a cycle where byte_valid && byte_ready.
    // byte_ready is a single-cycle strobe; byte_valid low in that cycle is an underrun.

    localparam int CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int MAX_FIELD = (EOP_SE0_BITS > 16) ? EOP_SE0_BITS : 16;
    localparam int BL_W      = $clog2(MAX_FIELD + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      shreg_q, shreg_d;
    logic [BL_W-1:0]  bits_q, bits_d;
    logic             last_q, last_d;
    logic             error_q, error_d;

    logic             strobe;
    logic             field_end;
    logic             fetch;
    logic             stall;
    logic             clear;
    logic             slot_load;
    logic             slot_bit;
    tx_state_e        slot_field;
    tx_state_e        new_field;
    logic [15:0]      new_val;
    logic [BL_W-1:0]  new_len;

`ifdef USB_TX_CRC16_EN
    logic [15:0] crc_q, crc_d;
    logic        crc_en_q, crc_en_d;
    logic        pid_q, pid_d;
`else
    logic unused_crc_append;
    assign unused_crc_append = crc_append;
`endif

    assign strobe    = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);
    // bits_q counts bits of the current field not yet put on the line
    assign field_end = (bits_q == '0);
    assign fetch     = strobe && field_end &&
                       ((state_q == ST_SYNC) || ((state_q == ST_DATA) && !last_q));

    // Field that follows the current one once its last bit has been on the line
    always_comb begin
        new_field = ST_IDLE;
        new_val   = '0;
        new_len   = '0;
        case (state_q)
            ST_SYNC, ST_DATA: begin
                if ((state_q == ST_SYNC) || !last_q) begin
                    if (byte_valid) begin
                        new_field = ST_DATA;
                        new_val   = {8'h00, byte_data};
                    end else begin
                        new_field = ST_ABORT;
                        new_val   = 16'h00FF;
                    end
                    new_len = BL_W'(8);
                end else begin
                    new_field = ST_EOP_SE0;
                    new_len   = BL_W'(EOP_SE0_BITS);
`ifdef USB_TX_CRC16_EN
                    if (crc_en_q) begin
                        new_field = ST_CRC;
                        new_val   = ~crc_q;
                        new_len   = BL_W'(16);
                    end
`endif
                end
            end
            ST_CRC, ST_ABORT: begin
                new_field = ST_EOP_SE0;
                new_len   = BL_W'(EOP_SE0_BITS);
            end
            ST_EOP_SE0: begin
                new_field = ST_EOP_J;
                new_len   = BL_W'(1);
            end
            default: begin
                new_field = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        bits_d     = bits_q;
        last_d     = last_q;
        error_d    = 1'b0;
        clear      = 1'b0;
        slot_load  = 1'b0;
        slot_field = state_q;
        slot_bit   = shreg_q[0];
        byte_ready = fetch;
`ifdef USB_TX_CRC16_EN
        crc_d      = crc_q;
        crc_en_d   = crc_en_q;
        pid_d      = pid_q;
`endif

        if (state_q == ST_IDLE) begin
            if (tx_start) begin
                clear      = 1'b1;
                slot_load  = 1'b1;
                slot_field = ST_SYNC;
                slot_bit   = SYNC_BYTE[0];
                state_d    = ST_SYNC;
                cnt_d      = '0;
                shreg_d    = {9'h000, SYNC_BYTE[7:1]};
                bits_d     = BL_W'(7);
                last_d     = 1'b0;
`ifdef USB_TX_CRC16_EN
                crc_d      = CRC16_INIT;
                crc_en_d   = crc_append;
                pid_d      = 1'b1;
`endif
            end
        end else begin
            cnt_d = strobe ? '0 : cnt_q + 1'b1;
            if (strobe) begin
                if (!field_end) begin
                    slot_load = 1'b1;
                    if (!stall) begin
                        shreg_d = shreg_q >> 1;
                        bits_d  = bits_q - 1'b1;
                    end
                end else if (new_field == ST_IDLE) begin
                    state_d = ST_IDLE;
                end else begin
                    // a pending stuff bit takes this slot; the new field starts one bit later
                    slot_load  = 1'b1;
                    slot_field = new_field;
                    slot_bit   = new_val[0];
                    state_d    = new_field;
                    if (stall) begin
                        shreg_d = new_val;
                        bits_d  = new_len;
                    end else begin
                        shreg_d = new_val >> 1;
                        bits_d  = new_len - 1'b1;
                    end
                    if (fetch) begin
                        if (byte_valid) begin
                            last_d = byte_last;
`ifdef USB_TX_CRC16_EN
                            if (!pid_q) begin
                                crc_d = crc16_byte(crc_q, byte_data);
                            end
                            pid_d = 1'b0;
`endif
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            bits_q   <= '0;
            last_q   <= 1'b0;
            error_q  <= 1'b0;
`ifdef USB_TX_CRC16_EN
            crc_q    <= '0;
            crc_en_q <= 1'b0;
            pid_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            bits_q   <= bits_d;
            last_q   <= last_d;
            error_q  <= error_d;
`ifdef USB_TX_CRC16_EN
            crc_q    <= crc_d;
            crc_en_q <= crc_en_d;
            pid_q    <= pid_d;
`endif
        end
    end

    usb_tx_line_encoder u_line_encoder (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (clear),
        .load          (slot_load),
        .bit_in        (slot_bit),
        .force_se0     (slot_field == ST_EOP_SE0),
        .force_j       (slot_field == ST_EOP_J),
        .stuff_disable (slot_field == ST_ABORT),
        .stall         (stall),
        .dplus_out     (dplus_out),
        .dminus_out    (dminus_out)
    );

    assign tx_active = (state_q != ST_IDLE);
    assign tx_error  = error_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Self-checking bench for usb_tx_serializer: per-bit-time line model with stuffing/NRZI, directed and random packets.
module tb_usb_tx_serializer;

    localparam int         CPB  = 8;
    localparam logic [7:0] SYNC = 8'h80;
    localparam int         EOPN = 2;
    localparam logic [1:0] LJ   = 2'b10;
    localparam logic [1:0] LK   = 2'b01;
    localparam logic [1:0] LSE0 = 2'b00;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       tx_start = 1'b0;
    logic       crc_append = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_last = 1'b0;
    logic       byte_ready, tx_active, tx_error, dplus_out, dminus_out;
    usb_tx_pkg::tx_state_e dbg_state;

    usb_tx_serializer #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(SYNC), .EOP_SE0_BITS(EOPN)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx_start   (tx_start),
        .crc_append (crc_append),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .tx_active  (tx_active),
        .tx_error   (tx_error),
        .dplus_out  (dplus_out),
        .dminus_out (dminus_out),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // packet under test
    logic [7:0] pkt [8];
    int         pkt_n;
    int         pkt_under;
    bit         pkt_crc;

    // scoreboard: expected line symbol per bit time
    logic [1:0] exp_q[$];
    int         fetch_q[$];
    int         err_cycle;
    int         m_ones;
    bit         m_lvl_j;
    int         m_last;

`ifdef USB_TX_CRC16_EN
    function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
        return c;
    endfunction
`endif

    task automatic model_bit(input bit b, input bit stuffable);
        if (!b) m_lvl_j = !m_lvl_j;
        exp_q.push_back(m_lvl_j ? LJ : LK);
        m_last = exp_q.size() - 1;
        if (b && stuffable) begin
            m_ones++;
            if (m_ones == 6) begin
                m_lvl_j = !m_lvl_j;
                exp_q.push_back(m_lvl_j ? LJ : LK);
                m_ones = 0;
            end
        end else begin
            m_ones = 0;
        end
    endtask

    task automatic build_model();
        logic [7:0] s;
`ifdef USB_TX_CRC16_EN
        logic [15:0] crc;
        crc = 16'hFFFF;
`endif
        s = SYNC;
        exp_q.delete();
        fetch_q.delete();
        err_cycle = -1;
        m_ones    = 0;
        m_lvl_j   = 1'b1;
        m_last    = 0;
        for (int i = 0; i < 8; i++) model_bit(s[i], 1'b1);
        for (int i = 0; i < pkt_n; i++) begin
            fetch_q.push_back(m_last);
            if (i == pkt_under) begin
                err_cycle = (m_last + 1) * CPB + 1;
                for (int b = 0; b < 8; b++) model_bit(1'b1, 1'b0);
                break;
            end
            for (int b = 0; b < 8; b++) model_bit(pkt[i][b], 1'b1);
`ifdef USB_TX_CRC16_EN
            if (i > 0) for (int b = 0; b < 8; b++) crc = crc_bit(crc, pkt[i][b]);
`endif
        end
`ifdef USB_TX_CRC16_EN
        if (pkt_crc && pkt_under < 0) begin
            crc = ~crc;
            for (int b = 0; b < 16; b++) model_bit(crc[b], 1'b1);
        end
`endif
        for (int i = 0; i < EOPN; i++) exp_q.push_back(LSE0);
        exp_q.push_back(LJ);
    endtask

    // driver + per-cycle compare against the scoreboard
    task automatic run_packet(input int reset_at, input bit mid_start,
                              output int act, output int rdy, output int err);
        int  total;
        int  idx;
        bit  adv;
        logic [1:0] exp_line;
        bit  exp_rdy;
        total = exp_q.size() * CPB;
        idx = 0;
        adv = 1'b0;
        act = 0; rdy = 0; err = 0;
        @(negedge clk);
        byte_data  = pkt[0];
        byte_valid = (pkt_under != 0);
        byte_last  = (pkt_n == 1);
        tx_start   = 1'b1;
        crc_append = pkt_crc;
        for (int k = 1; k <= total + 2; k++) begin
            @(negedge clk);
            tx_start   = mid_start && (k == 9 * CPB + 3);
            crc_append = 1'($urandom_range(0, 1));
            if (adv) idx++;
            byte_data  = (idx < pkt_n) ? pkt[idx] : 8'($urandom_range(0, 255));
            byte_valid = (idx < pkt_n) && (idx != pkt_under);
            byte_last  = (idx == pkt_n - 1);
            exp_line = (k <= total) ? exp_q[(k - 1) / CPB] : LJ;
            exp_rdy = 1'b0;
            foreach (fetch_q[j]) if (k == (fetch_q[j] + 1) * CPB) exp_rdy = 1'b1;
            check_eq("line", 32'({dplus_out, dminus_out}), 32'(exp_line));
            check_eq("tx_active", 32'(tx_active), 32'(k <= total));
            check_eq("byte_ready", 32'(byte_ready), 32'(exp_rdy));
            check_eq("tx_error", 32'(tx_error), 32'(k == err_cycle));
            act += int'(tx_active);
            rdy += int'(byte_ready);
            err += int'(tx_error);
            adv = byte_ready && byte_valid;
            if (k == reset_at) begin
                #2 n_rst = 1'b0;
                #1;
                check_eq("rst_line", 32'({dplus_out, dminus_out}), 32'(LJ));
                check_eq("rst_active", 32'(tx_active), 32'd0);
                check_eq("rst_ready", 32'(byte_ready), 32'd0);
                break;
            end
        end
        tx_start = 1'b0;
        if (reset_at > 0) begin
            repeat (3) @(negedge clk);
            n_rst = 1'b1;
            for (int k = 0; k < 4 * CPB; k++) begin
                @(negedge clk);
                byte_valid = 1'($urandom_range(0, 1));
                check_eq("post_rst_ready", 32'(byte_ready), 32'd0);
                check_eq("post_rst_line", 32'({dplus_out, dminus_out}), 32'(LJ));
                check_eq("post_rst_active", 32'(tx_active), 32'd0);
            end
        end
        check_eq("end_state_idle", 32'(dbg_state), 32'(usb_tx_pkg::ST_IDLE));
    endtask

    task automatic set_pkt(input int n, input int under, input bit crc);
        pkt_n = n;
        pkt_under = under;
        pkt_crc = crc;
        build_model();
    endtask

    int act, rdy, err;

    initial begin
        repeat (3) @(negedge clk);
        check_eq("reset_line", 32'({dplus_out, dminus_out}), 32'(LJ));
        check_eq("reset_active", 32'(tx_active), 32'd0);
        check_eq("reset_ready", 32'(byte_ready), 32'd0);
        check_eq("reset_error", 32'(tx_error), 32'd0);
        check_eq("reset_state", 32'(dbg_state), 32'(usb_tx_pkg::ST_IDLE));
        n_rst = 1'b1;
        repeat (4) @(negedge clk);

        pkt[0] = 8'hA5;
        set_pkt(1, -1, 1'b0);
        run_packet(0, 1'b0, act, rdy, err);
        check_eq("a5_active_clks", 32'(act), 32'd152);
        check_eq("a5_ready_cnt", 32'(rdy), 32'd1);
        check_eq("a5_error_cnt", 32'(err), 32'd0);

        pkt[0] = 8'hFF; pkt[1] = 8'hFF;
        set_pkt(2, -1, 1'b0);
        run_packet(0, 1'b0, act, rdy, err);
        check_eq("ffff_active_clks", 32'(act), 32'd232);
        check_eq("ffff_ready_cnt", 32'(rdy), 32'd2);

        pkt[0] = 8'hC3; pkt[1] = 8'h5A;
        set_pkt(2, 1, 1'b0);
        run_packet(0, 1'b0, act, rdy, err);
        check_eq("underrun_error_cnt", 32'(err), 32'd1);
        check_eq("underrun_active_clks", 32'(act), 32'd216);
        check_eq("underrun_ready_cnt", 32'(rdy), 32'd2);

`ifdef USB_TX_CRC16_EN
        pkt[0] = 8'hC3;
        set_pkt(1, -1, 1'b1);
        run_packet(0, 1'b0, act, rdy, err);
        check_eq("crc_pid_active_clks", 32'(act), 32'd280);
        check_eq("crc_pid_ready_cnt", 32'(rdy), 32'd1);
`endif

        pkt[0] = 8'hA5;
        set_pkt(1, -1, 1'b0);
        run_packet(0, 1'b1, act, rdy, err);
        check_eq("midstart_active_clks", 32'(act), 32'd152);
        check_eq("midstart_ready_cnt", 32'(rdy), 32'd1);

        for (int i = 0; i < 3; i++) pkt[i] = 8'($urandom_range(0, 255));
        set_pkt(3, -1, 1'b0);
        run_packet(8 * CPB + 20, 1'b0, act, rdy, err);

        for (int t = 0; t < 40; t++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++)
                pkt[i] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            set_pkt(n, ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1,
                    1'($urandom_range(0, 1)));
            run_packet(0, 1'($urandom_range(0, 1)), act, rdy, err);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
